// File: rtl/uart_rx_multi_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_multi_sampler
//
// Oversampling bit recovery for the UART receive path. The raw RX line is
// optionally synchronised, then sampled on an odd-sized window of edges
// centred on mid-bit. The bit is resolved by majority vote. A window whose
// samples do not all agree is reported as noise.
//
// Ports
//   CLK           system clock, rising edge
//   RST           asynchronous reset, active low
//   RX_IN         raw serial line (idle 1)
//   Sample_En     sampling enable from the Rx FSM
//   Prescale      edges per bit
//   Edge_Cnt      edge index inside the current bit (0..Prescale-1)
//   Num_Samples   requested vote window size
//   Sampled_Bit   majority result of the last completed window
//   Sample_Valid  one-cycle strobe marking a new Sampled_Bit/Noise_Err
//   Noise_Err     last completed window was not unanimous
//
// Output handshake: there is no back-pressure. Sample_Valid is high for
// exactly one cycle per completed window. Sampled_Bit and Noise_Err are
// meaningful in that cycle, and they hold until the next strobe.
// ---------------------------------------------------------------------------
module uart_rx_multi_sampler #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int MAX_SAMPLES    = 7,
  parameter int SYNC_STAGES    = 2,
  parameter int NS_WIDTH       = $clog2(MAX_SAMPLES + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      Sample_En,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
  input  logic [NS_WIDTH-1:0]       Num_Samples,
  output logic                      Sampled_Bit,
  output logic                      Sample_Valid,
  output logic                      Noise_Err
);

  localparam int CW = (NS_WIDTH > PRESCALE_WIDTH) ? NS_WIDTH : PRESCALE_WIDTH;
  localparam logic [NS_WIDTH-1:0] MAX_NS = NS_WIDTH'(MAX_SAMPLES);

  // -------------------------------------------------------------------------
  // Input synchronizer
  // -------------------------------------------------------------------------
  logic rx_s;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = RX_IN;
      end

      // Flops reset to the idle level so that reset is not seen as a start bit.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= '1;
        else      sync_q <= sync_d;
      end

      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Window geometry from the live configuration inputs
  // -------------------------------------------------------------------------
  logic [NS_WIDTH-1:0]       n_clamp;
  logic [CW-1:0]             half_req;
  logic [CW-1:0]             heff_cw;
  logic [PRESCALE_WIDTH-1:0] mid_new;
  logic [PRESCALE_WIDTH-1:0] upper_new;
  logic [PRESCALE_WIDTH-1:0] heff_new;

  always_comb begin
    n_clamp = Num_Samples;
    if (Num_Samples == '0)        n_clamp = NS_WIDTH'(1);
    else if (Num_Samples > MAX_NS) n_clamp = MAX_NS;
    // Even sizes round down so the window stays symmetric around mid-bit.
    if (!n_clamp[0]) n_clamp = n_clamp - NS_WIDTH'(1);

    half_req = CW'(n_clamp >> 1);
    mid_new  = Prescale >> 1;
    // Room to the right of mid-bit. Prescale of 0 is guarded so it cannot
    // underflow.
    upper_new = (Prescale == '0) ? '0 : (Prescale - PRESCALE_WIDTH'(1) - mid_new);

    heff_cw = half_req;
    if (CW'(mid_new) < heff_cw)   heff_cw = CW'(mid_new);
    if (CW'(upper_new) < heff_cw) heff_cw = CW'(upper_new);
    heff_new = PRESCALE_WIDTH'(heff_cw);
  end

  // -------------------------------------------------------------------------
  // Latched configuration. It is reloaded between bits (Sample_En low or
  // Edge_Cnt at 0), so a mid-bit change cannot reshape a running window.
  // In a reload cycle the fresh values are used directly. This lets a
  // window that begins at Edge_Cnt 0 use the new geometry.
  // -------------------------------------------------------------------------
  logic [PRESCALE_WIDTH-1:0] mid_q,  mid_d;
  logic [PRESCALE_WIDTH-1:0] heff_q, heff_d;
  logic                      cfg_load;
  logic [PRESCALE_WIDTH-1:0] win_lo;
  logic [PRESCALE_WIDTH-1:0] win_hi;

  assign cfg_load = !Sample_En || (Edge_Cnt == '0);
  assign mid_d    = cfg_load ? mid_new  : mid_q;
  assign heff_d   = cfg_load ? heff_new : heff_q;
  assign win_lo   = mid_d - heff_d;
  assign win_hi   = mid_d + heff_d;

  // -------------------------------------------------------------------------
  // Vote counters and outputs
  // -------------------------------------------------------------------------
  logic [NS_WIDTH-1:0] ones_q,    ones_d;
  logic [NS_WIDTH-1:0] samples_q, samples_d;
  logic                bit_q,     bit_d;
  logic                valid_q,   valid_d;
  logic                noise_q,   noise_d;

  logic                edge_zero;
  logic                in_win;
  logic                last_edge;
  logic [NS_WIDTH-1:0] ones_base;
  logic [NS_WIDTH-1:0] samples_base;
  logic [NS_WIDTH-1:0] heff_ns;
  logic [NS_WIDTH:0]   ones_total;
  logic [NS_WIDTH:0]   n_eff;

  always_comb begin
    edge_zero = (Edge_Cnt == '0);
    in_win    = (Edge_Cnt >= win_lo) && (Edge_Cnt <= win_hi);
    last_edge = (Edge_Cnt == win_hi);
    // Edge 0 begins a new bit. Anything still accumulated there is a
    // leftover partial window and must not contribute.
    ones_base    = edge_zero ? '0 : ones_q;
    samples_base = edge_zero ? '0 : samples_q;
    heff_ns      = NS_WIDTH'(heff_d);
    n_eff        = {heff_ns, 1'b1};
    ones_total   = {1'b0, ones_base} + (NS_WIDTH + 1)'(rx_s);

    ones_d    = ones_q;
    samples_d = samples_q;
    bit_d     = bit_q;
    noise_d   = noise_q;
    valid_d   = 1'b0;

    if (!Sample_En) begin
      ones_d    = '0;
      samples_d = '0;
    end else if (last_edge) begin
      // The last edge counts itself. Its vote wins over the edge-0 clear,
      // which gives the single-sample case when Prescale < 2.
      bit_d     = (ones_total > {1'b0, heff_ns});
      noise_d   = (ones_total != '0) && (ones_total != n_eff);
      valid_d   = 1'b1;
      ones_d    = '0;
      samples_d = '0;
    end else if (in_win) begin
      ones_d    = ones_base;
      samples_d = samples_base;
      // A held Edge_Cnt keeps counting. The sample counter saturates, which
      // keeps both counters from wrapping (ones never exceed samples).
      if (samples_base != '1) begin
        ones_d    = ones_base + NS_WIDTH'(rx_s);
        samples_d = samples_base + NS_WIDTH'(1);
      end
    end else if (edge_zero) begin
      ones_d    = '0;
      samples_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mid_q     <= '0;
      heff_q    <= '0;
      ones_q    <= '0;
      samples_q <= '0;
      bit_q     <= 1'b1;
      valid_q   <= 1'b0;
      noise_q   <= 1'b0;
    end else begin
      mid_q     <= mid_d;
      heff_q    <= heff_d;
      ones_q    <= ones_d;
      samples_q <= samples_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      noise_q   <= noise_d;
    end
  end

  assign Sampled_Bit  = bit_q;
  assign Sample_Valid = valid_q;
  assign Noise_Err    = noise_q;

endmodule

// File: doc/uart_rx_multi_sampler.md
Name: uart_rx_multi_sampler

Overview:
Oversampling bit-recovery block for the UART receiver data path. It has an optional input synchronizer and takes a programmable, odd number of samples centred on mid-bit. It resolves each bit by majority vote and flags non-unanimous windows as noise. It sits between the RX pin and the Rx FSM/deserializer, driven by the shared edge/bit counter.

Parameters:
PRESCALE_WIDTH, 6, width of Prescale and Edge_Cnt; oversampling ratio up to 2^PRESCALE_WIDTH-1.
MAX_SAMPLES, 7, largest supported vote window; must be odd and at least 1.
SYNC_STAGES, 2, flops in the RX_IN synchronizer; 0 bypasses the synchronizer.
NS_WIDTH, clog2(MAX_SAMPLES+1), width of Num_Samples and the internal ones-counter.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
RST  input  1  asynchronous, active-low reset.
RX_IN  input  1  raw serial line; idle level is 1.
Sample_En  input  1  sampling enable from the Rx FSM.
Prescale  input  PRESCALE_WIDTH  oversampling ratio (edges per bit).
Edge_Cnt  input  PRESCALE_WIDTH  edge index within the current bit, 0..Prescale-1.
Num_Samples  input  NS_WIDTH  requested vote window size.
Sampled_Bit  output  1  majority result of the last completed window.
Sample_Valid  output  1  one-cycle strobe; Sampled_Bit and Noise_Err are new.
Noise_Err  output  1  last completed window was not unanimous.

Behaviour:
- Reset (RST low, async):
  - Synchronizer flops reset to 1.
  - Sampled_Bit=1, Sample_Valid=0, Noise_Err=0.
  - Ones-counter, sample-counter and latched config reset to 0.
- Synchronizer:
  - RX_S is RX_IN delayed by SYNC_STAGES flops; RX_S = RX_IN combinationally when SYNC_STAGES=0.
  - Every sample uses RX_S.
- Window size:
  - N = Num_Samples clamped to [1, MAX_SAMPLES]; an even value is reduced by 1; 0 is treated as 1.
  - H = (N-1)/2 and Mid = Prescale>>1.
  - H_eff = min(H, Mid, Prescale-1-Mid). This keeps the window inside 0..Prescale-1.
  - The effective count is N_eff = 2*H_eff+1.
- Config latch:
  - Mid and H_eff are registered whenever Sample_En=0 or Edge_Cnt==0.
  - Prescale and Num_Samples changes mid-bit therefore take effect on the next bit only.
- Window: sampling happens at Edge_Cnt from Mid-H_eff to Mid+H_eff inclusive, only while Sample_En=1.
  - Each sample edge increments the sample-counter and adds RX_S to the ones-counter.
  - At the last edge (Edge_Cnt==Mid+H_eff), the vote includes the current RX_S.
  - Majority: ones_total > H_eff.
  - Noise_Err = (ones_total != 0) and (ones_total != N_eff).
  - Both are registered, with Sample_Valid=1 for exactly the next cycle.
  - The counters then clear.
- Latency: Sample_Valid is high in the cycle after the rising edge where Edge_Cnt==Mid+H_eff was seen.
- Hold: Sampled_Bit and Noise_Err hold their value until the next completed window. Sample_Valid is 0 otherwise.
- Edge_Cnt==0 with Sample_En=1 clears both counters (start of a new bit). This also discards a partial window if Edge_Cnt wrapped early.
- Sample_En deasserted at any point: counters clear next edge and no Sample_Valid is produced for that window. Outputs keep their last values.
- Edge_Cnt skipping or repeating a window index: each rising edge with a matching Edge_Cnt counts once. A held Edge_Cnt value is counted every cycle it is present. The Rx edge counter must advance one per cycle.
- Prescale < 2 (Mid=0, H_eff=0): single sample at Edge_Cnt==0. This sample takes priority over the clear, giving a 1-sample vote.
- Reset mid-window: everything returns to reset values immediately; no strobe is issued.

Test Plan:
1. SYNC_STAGES=0, Prescale=8, Num_Samples=3, RX=0 held, Edge_Cnt sweeping 0..7 -> samples at Edge_Cnt 3,4,5; Sample_Valid pulses once, the cycle after Edge_Cnt=5; Sampled_Bit=0, Noise_Err=0.
2. Prescale=16, Num_Samples=5, RX pattern 1,1,0,1,1 at Edge_Cnt 6..10 -> Sampled_Bit=1, Noise_Err=1; pattern 0,1,0,1,0 -> Sampled_Bit=0, Noise_Err=1.
3. Clamping:
   - Prescale=4, Num_Samples=7 -> H_eff=1, window is Edge_Cnt 1..3, N_eff=3.
   - Prescale=8, Num_Samples=6 -> treated as 5, window 2..6.
   - Num_Samples=0 -> single sample at Edge_Cnt 4.
4. Sample_En dropped at Edge_Cnt=Mid -> no Sample_Valid for that bit; Sampled_Bit keeps its prior value. Next full bit with Sample_En=1 produces a normal strobe.
5. SYNC_STAGES=2, RX_IN toggles 1→0 at Edge_Cnt=2 with Prescale=8, N=3 -> RX_S falls 2 cycles later. Samples at Edge_Cnt 3,4,5 see 1,0,0 -> Sampled_Bit=0, Noise_Err=1.
6. Assert RST low at Edge_Cnt=Mid during a window -> outputs go to 1/0/0 immediately with no strobe. After release, the next full window votes correctly.
